// File: rtl/fsm_input_conditioner.sv
// Pad conditioner for the vending-machine FSM: 2-flop sync, per-channel debounce,
// rising-edge pulse generation and coin/accept arbitration with one pending slot.
module fsm_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] raw_in,
  output logic       m_pulse,
  output logic       a_pulse,
  output logic       btnc_pulse,
  output logic       btnd_pulse,
  output logic [3:0] db_level,
  output logic       accept_pend
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACC_PEND,
    ARB_COIN_PEND
  } arb_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync_q1, sync_q2;
  logic [CNT_W-1:0] cnt      [4];
  logic [CNT_W-1:0] cnt_next [4];
  logic [3:0]       db_next;
  logic [3:0]       rise;
  arb_state_t       state, state_next;
  logic             m_next, a_next, c_next, d_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // A channel toggles on the edge its mismatch count would reach DEBOUNCE_CYCLES;
  // the rise flag is raised on that same edge so the pulse aligns with db_level.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      db_next[i]  = db_level[i];
      rise[i]     = 1'b0;
      if (!ena) begin
        cnt_next[i] = '0;
      end else if (sync_q2[i] != db_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i]  = ~db_level[i];
          cnt_next[i] = '0;
          rise[i]     = ~db_level[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end else begin
        cnt_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      db_level <= '0;
    end else begin
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
      db_level <= db_next;
    end
  end

  // Reset buttons bypass arbitration and flush any pending credit; otherwise a
  // pending pulse is served before fresh ones, and coin beats accept on a tie.
  always_comb begin
    state_next = state;
    m_next     = 1'b0;
    a_next     = 1'b0;
    c_next     = rise[2];
    d_next     = rise[3];
    if (!ena || rise[2] || rise[3]) begin
      state_next = ARB_IDLE;
    end else begin
      case (state)
        ARB_ACC_PEND: begin
          a_next     = 1'b1;
          state_next = rise[0] ? ARB_COIN_PEND : ARB_IDLE;
        end
        ARB_COIN_PEND: begin
          m_next     = 1'b1;
          state_next = rise[1] ? ARB_ACC_PEND : ARB_IDLE;
        end
        default: begin
          if (rise[0]) begin
            m_next     = 1'b1;
            state_next = rise[1] ? ARB_ACC_PEND : ARB_IDLE;
          end else if (rise[1]) begin
            a_next = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      m_pulse    <= 1'b0;
      a_pulse    <= 1'b0;
      btnc_pulse <= 1'b0;
      btnd_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      m_pulse    <= m_next;
      a_pulse    <= a_next;
      btnc_pulse <= c_next;
      btnd_pulse <= d_next;
    end
  end

  assign accept_pend = (state == ARB_ACC_PEND);

endmodule
